// File: rtl/sdram_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sdram_ctrl_fsm
// Description : SDR-SDRAM command sequencer. It runs the power-up init
//               sequence, then serves closed-page single-beat reads and
//               writes (ACT -> RD/WR with auto-precharge), and inserts an
//               auto-refresh at a fixed interval.
//               All SDRAM pins are driven from registers. Every timing
//               parameter is expressed in clk_i cycles.
// Ports       : clk_i, rst_i            clock, synchronous active-high reset
//               req_valid_i/req_ready_o request handshake
//               req_we_i                1 = write, 0 = read
//               req_addr_i              {bank,row,col}
//               rd_valid_o              one-cycle pulse when read data is on DQ
//               init_done_o             high once the init sequence has finished
//               ic_CS/RAS/CAS/WE/CKE_o  command pins
//               ic_BA_o, ic_A_o         bank and address pins
//               sr_req_i/sr_active_o    self-refresh request and status
//                                       (present only with SDRAM_SELF_REFRESH_EN)
// Config      : define SDRAM_SELF_REFRESH_EN to add the self-refresh states
//               and ports. The default build has no self-refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_ctrl_fsm #(
    parameter int BANK_W_p    = 2,
    parameter int ROW_W_p     = 13,
    parameter int COL_W_p     = 9,
    parameter int INIT_WAIT_p = 26600,
    parameter int RP_p        = 2,
    parameter int RCD_p       = 2,
    parameter int MRD_p       = 2,
    parameter int RFC_p       = 9,
    parameter int WR_p        = 2,
    parameter int CAS_p       = 2,
    parameter int REF_INT_p   = 1040,
    parameter int XSR_p       = 75,
    parameter logic [ROW_W_p-1:0] MODE_p = 13'h020
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic                                req_we_i,
    input  logic [BANK_W_p+ROW_W_p+COL_W_p-1:0] req_addr_i,
    output logic                                rd_valid_o,
    output logic                                init_done_o,
    output logic                                ic_CS_o,
    output logic                                ic_RAS_o,
    output logic                                ic_CAS_o,
    output logic                                ic_WE_o,
    output logic                                ic_CKE_o,
    output logic [BANK_W_p-1:0]                 ic_BA_o,
    output logic [ROW_W_p-1:0]                  ic_A_o
`ifdef SDRAM_SELF_REFRESH_EN
    ,
    input  logic                                sr_req_i,
    output logic                                sr_active_o
`endif
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The wait counter must be able to hold the longest timing that any state waits for.
    localparam int c_MAX_T = f_max(f_max(f_max(INIT_WAIT_p, RFC_p), f_max(XSR_p, CAS_p + RP_p)),
                                   f_max(f_max(WR_p + RP_p, RCD_p), f_max(MRD_p, RP_p)));
    localparam int c_CNT_W = $clog2(c_MAX_T) + 1;
    localparam int c_REF_W = $clog2(REF_INT_p) + 1;

    // Wait-counter values at which the next command may be issued.
    // A command issued in cycle C clears the counter. In cycle C+t the counter reads t-1.
    localparam logic [c_CNT_W-1:0] c_TGT_INIT = c_CNT_W'(INIT_WAIT_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_RP   = c_CNT_W'(RP_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_RFC  = c_CNT_W'(RFC_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_MRD  = c_CNT_W'(MRD_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_RCD  = c_CNT_W'(RCD_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_CAS  = c_CNT_W'(CAS_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_RDX  = c_CNT_W'(CAS_p + RP_p - 1);
    localparam logic [c_CNT_W-1:0] c_TGT_WRX  = c_CNT_W'(WR_p + RP_p - 1);
`ifdef SDRAM_SELF_REFRESH_EN
    localparam logic [c_CNT_W-1:0] c_TGT_XSR  = c_CNT_W'(XSR_p - 1);
`endif
    localparam logic [c_REF_W-1:0] c_REF_RELOAD = c_REF_W'(REF_INT_p - 1);

    // Command encoding {CS,RAS,CAS,WE}
    localparam logic [3:0] c_CMD_NOP = 4'b0111;
    localparam logic [3:0] c_CMD_ACT = 4'b0011;
    localparam logic [3:0] c_CMD_RD  = 4'b0101;
    localparam logic [3:0] c_CMD_WR  = 4'b0100;
    localparam logic [3:0] c_CMD_PRE = 4'b0010;
    localparam logic [3:0] c_CMD_REF = 4'b0001;
    localparam logic [3:0] c_CMD_MRS = 4'b0000;

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PRE  = 4'd1;
    localparam logic [3:0] S_INIT_REF1 = 4'd2;
    localparam logic [3:0] S_INIT_REF2 = 4'd3;
    localparam logic [3:0] S_INIT_MRS  = 4'd4;
    localparam logic [3:0] S_IDLE      = 4'd5;
    localparam logic [3:0] S_ACT       = 4'd6;
    localparam logic [3:0] S_RD        = 4'd7;
    localparam logic [3:0] S_WR        = 4'd8;
    localparam logic [3:0] S_REF       = 4'd9;
`ifdef SDRAM_SELF_REFRESH_EN
    localparam logic [3:0] S_SR        = 4'd10;
    localparam logic [3:0] S_SR_EXIT   = 4'd11;
`endif

    logic [3:0]          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt, w_tgt;
    logic [c_REF_W-1:0]  r_ref_cnt, w_ref_cnt_nxt;
    logic                r_ref_pend, w_ref_pend_nxt;
    logic                w_ref_issue;
    logic                r_we, w_we_nxt;
    logic [BANK_W_p-1:0] r_bank, w_bank_nxt;
    logic [COL_W_p-1:0]  r_col, w_col_nxt;
    logic [3:0]          r_cmd, w_cmd_nxt;
    logic                r_cke, w_cke_nxt;
    logic [BANK_W_p-1:0] r_ba, w_ba_nxt;
    logic [ROW_W_p-1:0]  r_a, w_a_nxt;
    logic [ROW_W_p-1:0]  w_a_col;
    logic [ROW_W_p-1:0]  w_a_pre_all;
    logic                r_ready, w_ready_nxt;
    logic                r_rd_valid, w_rd_valid_nxt;
    logic                r_init_done, w_init_done_nxt;
`ifdef SDRAM_SELF_REFRESH_EN
    logic                r_sr_active, w_sr_active_nxt;
`endif

    always_comb begin
        // The column address carries A10=1 so that the access auto-precharges.
        w_a_col                 = '0;
        w_a_col[COL_W_p-1:0]    = r_col;
        w_a_col[10]             = 1'b1;
        // A10=1 on PRE selects all banks.
        w_a_pre_all             = '0;
        w_a_pre_all[10]         = 1'b1;

        w_state_nxt      = r_state;
        w_tgt            = '0;
        w_cmd_nxt        = c_CMD_NOP;
        w_cke_nxt        = r_cke;
        w_ba_nxt         = r_ba;
        w_a_nxt          = r_a;
        w_we_nxt         = r_we;
        w_bank_nxt       = r_bank;
        w_col_nxt        = r_col;
        w_ref_issue      = 1'b0;
        w_init_done_nxt  = r_init_done;
`ifdef SDRAM_SELF_REFRESH_EN
        w_sr_active_nxt  = r_sr_active;
`endif

        case (r_state)
            S_INIT_WAIT: w_tgt = c_TGT_INIT;
            S_INIT_PRE:  w_tgt = c_TGT_RP;
            S_INIT_REF1: w_tgt = c_TGT_RFC;
            S_INIT_REF2: w_tgt = c_TGT_RFC;
            S_INIT_MRS:  w_tgt = c_TGT_MRD;
            S_ACT:       w_tgt = c_TGT_RCD;
            S_RD:        w_tgt = c_TGT_RDX;
            S_WR:        w_tgt = c_TGT_WRX;
            S_REF:       w_tgt = c_TGT_RFC;
`ifdef SDRAM_SELF_REFRESH_EN
            S_SR_EXIT:   w_tgt = c_TGT_XSR;
`endif
            default:     w_tgt = '0;
        endcase

        // The counter saturates at the current target.
        // Every state change below restarts it from zero.
        w_cnt_nxt = (r_cnt == w_tgt) ? r_cnt : r_cnt + 1'b1;

        case (r_state)
            S_INIT_WAIT: if (r_cnt == w_tgt) begin
                w_cmd_nxt   = c_CMD_PRE;
                w_ba_nxt    = '0;
                w_a_nxt     = w_a_pre_all;
                w_state_nxt = S_INIT_PRE;
                w_cnt_nxt   = '0;
            end
            S_INIT_PRE: if (r_cnt == w_tgt) begin
                w_cmd_nxt   = c_CMD_REF;
                w_ref_issue = 1'b1;
                w_state_nxt = S_INIT_REF1;
                w_cnt_nxt   = '0;
            end
            S_INIT_REF1: if (r_cnt == w_tgt) begin
                w_cmd_nxt   = c_CMD_REF;
                w_ref_issue = 1'b1;
                w_state_nxt = S_INIT_REF2;
                w_cnt_nxt   = '0;
            end
            S_INIT_REF2: if (r_cnt == w_tgt) begin
                w_cmd_nxt   = c_CMD_MRS;
                w_ba_nxt    = '0;
                w_a_nxt     = MODE_p;
                w_state_nxt = S_INIT_MRS;
                w_cnt_nxt   = '0;
            end
            S_INIT_MRS: if (r_cnt == w_tgt) begin
                w_state_nxt     = S_IDLE;
                w_init_done_nxt = 1'b1;
                w_cnt_nxt       = '0;
            end
            S_IDLE: begin
                // r_ready is only high while no refresh is pending.
                // An accepted request therefore never collides with a pending REF.
                if (req_valid_i && r_ready) begin
                    w_cmd_nxt   = c_CMD_ACT;
                    w_ba_nxt    = req_addr_i[BANK_W_p+ROW_W_p+COL_W_p-1 -: BANK_W_p];
                    w_a_nxt     = req_addr_i[COL_W_p +: ROW_W_p];
                    w_we_nxt    = req_we_i;
                    w_bank_nxt  = req_addr_i[BANK_W_p+ROW_W_p+COL_W_p-1 -: BANK_W_p];
                    w_col_nxt   = req_addr_i[COL_W_p-1:0];
                    w_state_nxt = S_ACT;
                    w_cnt_nxt   = '0;
                end else if (r_ref_pend) begin
                    w_cmd_nxt   = c_CMD_REF;
                    w_ref_issue = 1'b1;
                    w_state_nxt = S_REF;
                    w_cnt_nxt   = '0;
                end
`ifdef SDRAM_SELF_REFRESH_EN
                else if (sr_req_i) begin
                    // REF with CKE low enters self-refresh.
                    w_cmd_nxt       = c_CMD_REF;
                    w_cke_nxt       = 1'b0;
                    w_ref_issue     = 1'b1;
                    w_sr_active_nxt = 1'b1;
                    w_state_nxt     = S_SR;
                    w_cnt_nxt       = '0;
                end
`endif
            end
            S_ACT: if (r_cnt == w_tgt) begin
                w_cmd_nxt   = r_we ? c_CMD_WR : c_CMD_RD;
                w_ba_nxt    = r_bank;
                w_a_nxt     = w_a_col;
                w_state_nxt = r_we ? S_WR : S_RD;
                w_cnt_nxt   = '0;
            end
            S_RD, S_WR, S_REF: if (r_cnt == w_tgt) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
`ifdef SDRAM_SELF_REFRESH_EN
            S_SR: if (!sr_req_i) begin
                w_cke_nxt       = 1'b1;
                w_sr_active_nxt = 1'b0;
                w_state_nxt     = S_SR_EXIT;
                w_cnt_nxt       = '0;
            end
            S_SR_EXIT: if (r_cnt == w_tgt) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
`endif
            default: begin
                w_state_nxt = S_INIT_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase

        // The refresh interval counts down and holds at zero.
        // The pending flag stays set until a REF is issued.
        if (w_ref_issue) begin
            w_ref_cnt_nxt = c_REF_RELOAD;
        end else if (r_ref_cnt != '0) begin
            w_ref_cnt_nxt = r_ref_cnt - 1'b1;
        end else begin
            w_ref_cnt_nxt = r_ref_cnt;
        end
`ifdef SDRAM_SELF_REFRESH_EN
        // The device refreshes itself while in self-refresh, so the interval restarts on exit.
        if (r_state == S_SR || r_state == S_SR_EXIT) begin
            w_ref_cnt_nxt = c_REF_RELOAD;
        end
`endif
        w_ref_pend_nxt = w_ref_issue ? 1'b0 : (r_ref_pend | (r_ref_cnt == '0));

        w_ready_nxt    = (w_state_nxt == S_IDLE) && !w_ref_pend_nxt;
`ifdef SDRAM_SELF_REFRESH_EN
        w_ready_nxt    = w_ready_nxt && !sr_req_i;
`endif
        w_rd_valid_nxt = (r_state == S_RD) && (r_cnt == c_TGT_CAS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_INIT_WAIT;
            r_cnt       <= '0;
            r_ref_cnt   <= c_REF_RELOAD;
            r_ref_pend  <= 1'b0;
            r_we        <= 1'b0;
            r_bank      <= '0;
            r_col       <= '0;
            r_cmd       <= c_CMD_NOP;
            r_cke       <= 1'b1;
            r_ba        <= '0;
            r_a         <= '0;
            r_ready     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_init_done <= 1'b0;
`ifdef SDRAM_SELF_REFRESH_EN
            r_sr_active <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ref_cnt   <= w_ref_cnt_nxt;
            r_ref_pend  <= w_ref_pend_nxt;
            r_we        <= w_we_nxt;
            r_bank      <= w_bank_nxt;
            r_col       <= w_col_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cke       <= w_cke_nxt;
            r_ba        <= w_ba_nxt;
            r_a         <= w_a_nxt;
            r_ready     <= w_ready_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_init_done <= w_init_done_nxt;
`ifdef SDRAM_SELF_REFRESH_EN
            r_sr_active <= w_sr_active_nxt;
`endif
        end
    end

    assign ic_CS_o     = r_cmd[3];
    assign ic_RAS_o    = r_cmd[2];
    assign ic_CAS_o    = r_cmd[1];
    assign ic_WE_o     = r_cmd[0];
    assign ic_CKE_o    = r_cke;
    assign ic_BA_o     = r_ba;
    assign ic_A_o      = r_a;
    assign req_ready_o = r_ready;
    assign rd_valid_o  = r_rd_valid;
    assign init_done_o = r_init_done;
`ifdef SDRAM_SELF_REFRESH_EN
    assign sr_active_o = r_sr_active;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_ctrl_fsm
// Description : Directed self-checking bench for sdram_ctrl_fsm, built with
//               INIT_WAIT_p=10 and every other parameter at its default.
//               Cycle k is the clock period that follows the k-th rising
//               edge after reset. Outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_ctrl_fsm;
    localparam int c_BW = 2;
    localparam int c_RW = 13;
    localparam int c_CW = 9;
    localparam int c_AW = c_BW + c_RW + c_CW;

    localparam logic [3:0] c_NOP = 4'b0111;
    localparam logic [3:0] c_ACT = 4'b0011;
    localparam logic [3:0] c_RD  = 4'b0101;
    localparam logic [3:0] c_WR  = 4'b0100;
    localparam logic [3:0] c_PRE = 4'b0010;
    localparam logic [3:0] c_REF = 4'b0001;
    localparam logic [3:0] c_MRS = 4'b0000;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_we_i = 1'b0;
    logic [c_AW-1:0] req_addr_i = '0;
    logic            rd_valid_o, init_done_o;
    logic            ic_CS_o, ic_RAS_o, ic_CAS_o, ic_WE_o, ic_CKE_o;
    logic [c_BW-1:0] ic_BA_o;
    logic [c_RW-1:0] ic_A_o;
`ifdef SDRAM_SELF_REFRESH_EN
    logic            sr_req_i = 1'b0;
    logic            sr_active_o;
`endif
    logic [3:0]      w_cmd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    assign w_cmd = {ic_CS_o, ic_RAS_o, ic_CAS_o, ic_WE_o};

    always #5 clk_i = ~clk_i;

    sdram_ctrl_fsm #(.INIT_WAIT_p(10)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .rd_valid_o  (rd_valid_o),
        .init_done_o (init_done_o),
        .ic_CS_o     (ic_CS_o),
        .ic_RAS_o    (ic_RAS_o),
        .ic_CAS_o    (ic_CAS_o),
        .ic_WE_o     (ic_WE_o),
        .ic_CKE_o    (ic_CKE_o),
        .ic_BA_o     (ic_BA_o),
        .ic_A_o      (ic_A_o)
`ifdef SDRAM_SELF_REFRESH_EN
        ,
        .sr_req_i    (sr_req_i),
        .sr_active_o (sr_active_o)
`endif
    );

    task automatic step();
        @(negedge clk_i);
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc = 0;
        checks++; if (w_cmd !== c_NOP) begin errors++; $display("FAIL reset_cmd: got %b expected %b", w_cmd, c_NOP); end
        checks++; if (ic_CKE_o !== 1'b1) begin errors++; $display("FAIL reset_cke: got %b expected 1", ic_CKE_o); end
        checks++; if (ic_BA_o !== '0 || ic_A_o !== '0) begin errors++; $display("FAIL reset_addr: got BA=%h A=%h expected 0/0", ic_BA_o, ic_A_o); end
        checks++; if (req_ready_o !== 1'b0 || rd_valid_o !== 1'b0 || init_done_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ready=%b rd_valid=%b init_done=%b expected 0/0/0", req_ready_o, rd_valid_o, init_done_o);
        end
    endtask

    task automatic test_init();
        logic [3:0] exp_cmd;
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_cmd = (k == 10) ? c_PRE : (k == 12 || k == 21) ? c_REF : (k == 30) ? c_MRS : c_NOP;
            checks++; if (w_cmd !== exp_cmd) begin errors++; $display("FAIL init_cmd c%0d: got %b expected %b", k, w_cmd, exp_cmd); end
            checks++; if (init_done_o !== (k == 32)) begin errors++; $display("FAIL init_done c%0d: got %b expected %b", k, init_done_o, (k == 32)); end
            if (k == 10) begin
                checks++; if (ic_A_o !== 13'h400) begin errors++; $display("FAIL init_pre_a10: got A=%h expected 400", ic_A_o); end
            end
            if (k == 30) begin
                checks++; if (ic_A_o !== 13'h020) begin errors++; $display("FAIL init_mrs_mode: got A=%h expected 020", ic_A_o); end
            end
        end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL init_ready: got %b expected 1", req_ready_o); end
    endtask

    task automatic test_read();
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = {2'd1, 13'd5, 9'd7};
        for (int k = 1; k <= 7; k++) begin
            step();
            req_valid_i = 1'b0;
            checks++; if (w_cmd !== ((k == 1) ? c_ACT : (k == 3) ? c_RD : c_NOP)) begin
                errors++; $display("FAIL read_cmd T+%0d: got %b", k, w_cmd);
            end
            checks++; if (rd_valid_o !== (k == 5)) begin errors++; $display("FAIL read_rd_valid T+%0d: got %b expected %b", k, rd_valid_o, (k == 5)); end
            checks++; if (req_ready_o !== (k == 7)) begin errors++; $display("FAIL read_ready T+%0d: got %b expected %b", k, req_ready_o, (k == 7)); end
            if (k == 1) begin
                checks++; if (ic_BA_o !== 2'd1 || ic_A_o !== 13'd5) begin errors++; $display("FAIL read_act_addr: got BA=%h A=%h expected 1/5", ic_BA_o, ic_A_o); end
            end
            if (k == 3) begin
                checks++; if (ic_BA_o !== 2'd1 || ic_A_o !== 13'h407) begin errors++; $display("FAIL read_rd_addr: got BA=%h A=%h expected 1/407", ic_BA_o, ic_A_o); end
            end
        end
    endtask

    task automatic test_write();
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = {2'd2, 13'h1abc, 9'h1ff};
        for (int k = 1; k <= 7; k++) begin
            step();
            req_valid_i = 1'b0;
            checks++; if (w_cmd !== ((k == 1) ? c_ACT : (k == 3) ? c_WR : c_NOP)) begin
                errors++; $display("FAIL write_cmd T+%0d: got %b", k, w_cmd);
            end
            checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL write_rd_valid T+%0d: got %b expected 0", k, rd_valid_o); end
            checks++; if (req_ready_o !== (k == 7)) begin errors++; $display("FAIL write_ready T+%0d: got %b expected %b", k, req_ready_o, (k == 7)); end
            if (k == 1) begin
                checks++; if (ic_BA_o !== 2'd2 || ic_A_o !== 13'h1abc) begin errors++; $display("FAIL write_act_addr: got BA=%h A=%h expected 2/1abc", ic_BA_o, ic_A_o); end
            end
            if (k == 3) begin
                checks++; if (ic_BA_o !== 2'd2 || ic_A_o !== 13'h5ff) begin errors++; $display("FAIL write_wr_addr: got BA=%h A=%h expected 2/5ff", ic_BA_o, ic_A_o); end
            end
        end
        req_we_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cmd;
        req_valid_i = 1'b1;
        req_addr_i  = {2'd0, 13'd9, 9'd3};
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k >= 8) req_valid_i = 1'b0;
            exp_cmd = (k == 1 || k == 8) ? c_ACT : (k == 3 || k == 10) ? c_RD : c_NOP;
            checks++; if (w_cmd !== exp_cmd) begin errors++; $display("FAIL b2b_cmd T+%0d: got %b expected %b", k, w_cmd, exp_cmd); end
            checks++; if (req_ready_o !== (k == 7 || k == 14)) begin errors++; $display("FAIL b2b_ready T+%0d: got %b", k, req_ready_o); end
            checks++; if (rd_valid_o !== (k == 5 || k == 12)) begin errors++; $display("FAIL b2b_rd_valid T+%0d: got %b", k, rd_valid_o); end
        end
    endtask

    task automatic test_refresh();
        bit found = 1'b0;
        logic [3:0] exp_cmd;
        for (int n = 0; n < 1200 && !found; n++) begin
            step();
            if (req_ready_o === 1'b0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL refresh_timeout: ready never dropped within 1200 cycles"); end
        // Last init REF in c21 reloads the counter to 1039, so it reads 0 in c1060 and the refresh is pending from c1061.
        checks++; if (cyc != 1061) begin errors++; $display("FAIL refresh_expiry_cycle: got c%0d expected c1061", cyc); end
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = {2'd3, 13'd0, 9'd0};
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k >= 11) req_valid_i = 1'b0;
            exp_cmd = (k == 1) ? c_REF : (k == 11) ? c_ACT : (k == 13) ? c_RD : c_NOP;
            checks++; if (w_cmd !== exp_cmd) begin errors++; $display("FAIL refresh_cmd X+%0d: got %b expected %b", k, w_cmd, exp_cmd); end
            checks++; if (req_ready_o !== (k == 10 || k == 17)) begin errors++; $display("FAIL refresh_ready X+%0d: got %b", k, req_ready_o); end
            checks++; if (rd_valid_o !== (k == 15)) begin errors++; $display("FAIL refresh_rd_valid X+%0d: got %b", k, rd_valid_o); end
            if (k == 11) begin
                checks++; if (ic_BA_o !== 2'd3 || ic_A_o !== 13'd0) begin errors++; $display("FAIL refresh_act_addr: got BA=%h A=%h expected 3/0", ic_BA_o, ic_A_o); end
            end
            if (k == 13) begin
                checks++; if (ic_A_o !== 13'h400) begin errors++; $display("FAIL refresh_rd_addr: got A=%h expected 400", ic_A_o); end
            end
        end
    endtask

`ifdef SDRAM_SELF_REFRESH_EN
    task automatic test_self_refresh();
        sr_req_i = 1'b1;
        for (int k = 1; k <= 79; k++) begin
            step();
            if (k == 1) begin
                checks++; if (w_cmd !== c_REF || ic_CKE_o !== 1'b0 || sr_active_o !== 1'b1) begin
                    errors++; $display("FAIL sr_entry: got cmd=%b cke=%b active=%b expected 0001/0/1", w_cmd, ic_CKE_o, sr_active_o);
                end
            end
            if (k == 3) begin
                checks++; if (w_cmd !== c_NOP || ic_CKE_o !== 1'b0) begin errors++; $display("FAIL sr_hold: got cmd=%b cke=%b expected 0111/0", w_cmd, ic_CKE_o); end
                sr_req_i = 1'b0;
            end
            if (k == 4) begin
                checks++; if (w_cmd !== c_NOP || ic_CKE_o !== 1'b1 || sr_active_o !== 1'b0) begin
                    errors++; $display("FAIL sr_exit: got cmd=%b cke=%b active=%b expected 0111/1/0", w_cmd, ic_CKE_o, sr_active_o);
                end
            end
            if (k == 78 || k == 79) begin
                checks++; if (req_ready_o !== (k == 79)) begin errors++; $display("FAIL sr_ready S+%0d: got %b expected %b", k, req_ready_o, (k == 79)); end
            end
        end
    endtask
`endif

    task automatic test_reset_mid_read();
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = {2'd1, 13'd5, 9'd7};
        for (int k = 1; k <= 4; k++) begin
            step();
            req_valid_i = 1'b0;
        end
        // Cycle T+4 is the cycle after RD. Reset is sampled at its closing edge.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        cyc = 0;
        checks++; if (w_cmd !== c_NOP || ic_CKE_o !== 1'b1) begin errors++; $display("FAIL midrst_cmd: got cmd=%b cke=%b expected 0111/1", w_cmd, ic_CKE_o); end
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %b expected 0", rd_valid_o); end
        checks++; if (req_ready_o !== 1'b0 || init_done_o !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ready=%b init_done=%b expected 0/0", req_ready_o, init_done_o); end
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++; if (w_cmd !== ((k == 10) ? c_PRE : c_NOP)) begin errors++; $display("FAIL midrst_init c%0d: got %b", k, w_cmd); end
            checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_no_rd_valid c%0d: got %b", k, rd_valid_o); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_read();
        test_write();
        test_back_to_back();
        test_refresh();
`ifdef SDRAM_SELF_REFRESH_EN
        test_self_refresh();
`endif
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
